// File: rtl/instr_fetch.sv
// Instruction fetch front-end: reads 32-bit instructions as two 16-bit beats,
// buffers them in a prefetch FIFO and hands them to the core on valid/ready.
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_q,
  input  logic        mem_gnt,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HI_PEND = 2'd1,
    S_NEED_LO = 2'd2,
    S_LO_PEND = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e        state_q, state_d;
  logic [15:0]   fpc_q, fpc_d;
  logic [15:0]   hi_q, hi_d;
  logic [15:0]   addr_q;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, count_after;
  entry_t        head_q, head_d;
  logic          valid_q, valid_d;
  entry_t        fifo_q [DEPTH];

  logic          issue;
  logic [15:0]   issue_addr;
  logic          push, pop, space;
  entry_t        push_entry;

  // Fetch sequencing, read issue and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    hi_d       = hi_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    push       = (state_q == S_LO_PEND) && !redirect;
    pop        = valid_q && instr_ready && !redirect;
    push_entry.pc   = fpc_q;
    push_entry.word = {hi_q, mem_q};
    count_after = count_q + CW'(push) - CW'(pop);
    // Space must also cover the instruction a new hi read would start
    space = ({1'b0, count_after} + (CW + 1)'(1)) <= DEPTH_W;

    if (redirect) begin
      state_d = S_IDLE;
      fpc_d   = redirect_pc;
    end else if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (space && mem_gnt) begin
            issue      = 1'b1;
            issue_addr = {fpc_q[14:0], 1'b0};
            state_d    = S_HI_PEND;
          end
        end
        S_HI_PEND: begin
          hi_d = mem_q;
          if (mem_gnt) begin
            issue      = 1'b1;
            issue_addr = {fpc_q[14:0], 1'b1};
            state_d    = S_LO_PEND;
          end else begin
            state_d = S_NEED_LO;
          end
        end
        S_NEED_LO: begin
          if (mem_gnt) begin
            issue      = 1'b1;
            issue_addr = {fpc_q[14:0], 1'b1};
            state_d    = S_LO_PEND;
          end
        end
        S_LO_PEND: begin
          fpc_d = fpc_q + 16'd1;
          if (space && mem_gnt) begin
            issue      = 1'b1;
            issue_addr = {fpc_d[14:0], 1'b0};
            state_d    = S_HI_PEND;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = count_after;
    end

    // New head is the entry being pushed when it lands in the head slot
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_entry;
    end else begin
      head_d = fifo_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      hi_q     <= '0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      hi_q     <= hi_d;
      addr_q   <= issue_addr;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (valid_d) begin
        head_q <= head_d;
      end
    end
  end

  // Storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  assign mem_rd      = issue;
  assign mem_addr    = issue_addr;
  assign instr       = head_q.word;
  assign instr_pc    = head_q.pc;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 16-bit synchronous memory model.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_q;
  logic        mem_gnt;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch #(.DEPTH(4), .RESET_PC(16'h0010)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .mem_gnt     (mem_gnt),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [65536];

  // Synchronous memory: data one cycle after mem_rd, junk otherwise
  always @(posedge clk) begin
    mem_q <= mem_rd ? mem[mem_addr] : 16'hBAD0;
  end

  int          cyc = 0;
  int          vrise = -1;
  logic [15:0] rd_log [$];
  int          rd_cyc [$];
  logic [47:0] pop_log [$];
  int          pop_cyc [$];

  always @(negedge clk) begin
    #2;
    cyc++;
    if (mem_rd) begin
      rd_log.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (instr_valid && instr_ready && !redirect) begin
      pop_log.push_back({instr_pc, instr});
      pop_cyc.push_back(cyc);
    end
    if (instr_valid && vrise < 0) vrise = cyc;
  end

  task automatic clear_logs();
    rd_log.delete();
    rd_cyc.delete();
    pop_log.delete();
    pop_cyc.delete();
    vrise = -1;
  endtask

  task automatic do_reset(input logic gnt, input logic rdy);
    @(negedge clk);
    rst_n    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    mem_gnt     = gnt;
    instr_ready = rdy;
    rst_n       = 1'b1;
    clear_logs();
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    #3;
    n_cmp++;
    if (pop_log.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pops, required %0d", tag, pop_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_gnt = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b, required 0", mem_rd); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0000", mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h, required 00000000", instr); end
    n_cmp++; if (instr_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h, required 0000", instr_pc); end
  endtask

  task automatic test_basic();
    do_reset(1'b1, 1'b1);
    wait_pops(2, "basic");
    n_cmp++; if (rd_log[0] !== 16'h0020) begin n_fail++; $display("FAIL basic_rd0: got %h, required 0020", rd_log[0]); end
    n_cmp++; if (rd_log[1] !== 16'h0021) begin n_fail++; $display("FAIL basic_rd1: got %h, required 0021", rd_log[1]); end
    n_cmp++; if (pop_log[0] !== {16'h0010, 32'h0A010203}) begin n_fail++; $display("FAIL basic_pop0: got %h, required 00100a010203", pop_log[0]); end
    n_cmp++; if (pop_log[1] !== {16'h0011, 32'hFFDDFFDC}) begin n_fail++; $display("FAIL basic_pop1: got %h, required 0011ffddffdc", pop_log[1]); end
    n_cmp++; if (vrise - rd_cyc[0] !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d, required 3", vrise - rd_cyc[0]); end
    n_cmp++; if (rd_cyc[2] - rd_cyc[0] !== 2) begin n_fail++; $display("FAIL basic_rate: got %0d, required 2", rd_cyc[2] - rd_cyc[0]); end
  endtask

  task automatic test_backpressure();
    logic [15:0] epc;
    do_reset(1'b1, 1'b0);
    repeat (30) @(negedge clk);
    #3;
    n_cmp++; if (rd_log.size() !== 8) begin n_fail++; $display("FAIL bp_reads: got %0d, required 8", rd_log.size()); end
    n_cmp++; if (rd_log[7] !== 16'h0027) begin n_fail++; $display("FAIL bp_last_rd: got %h, required 0027", rd_log[7]); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_idle_rd: got %b, required 0", mem_rd); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", instr_valid); end
    n_cmp++; if ({instr_pc, instr} !== {16'h0010, 32'h0A010203}) begin n_fail++; $display("FAIL bp_head: got %h %h, required 0010 0a010203", instr_pc, instr); end
    @(negedge clk);
    clear_logs();
    instr_ready = 1'b1;
    wait_pops(5, "bp");
    for (int i = 0; i < 4; i++) begin
      epc = 16'h0010 + 16'(i);
      n_cmp++;
      if (pop_log[i][47:32] !== epc) begin n_fail++; $display("FAIL bp_order%0d: got %h, required %h", i, pop_log[i][47:32], epc); end
    end
    n_cmp++; if (pop_cyc[3] - pop_cyc[0] !== 3) begin n_fail++; $display("FAIL bp_consecutive: got %0d, required 3", pop_cyc[3] - pop_cyc[0]); end
    n_cmp++; if (rd_log[0] !== 16'h0028) begin n_fail++; $display("FAIL bp_resume_rd: got %h, required 0028", rd_log[0]); end
    n_cmp++; if (pop_log[4] !== {16'h0014, 32'hFFD7FFD6}) begin n_fail++; $display("FAIL bp_resume_pop: got %h, required 0014ffd7ffd6", pop_log[4]); end
  endtask

  task automatic test_gnt_stall();
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_rd_c1: got %b, required 0", mem_rd); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_rd_hold%0d: got %b, required 0", i, mem_rd); end
      n_cmp++; if (mem_addr !== 16'h0020) begin n_fail++; $display("FAIL stall_addr_hold%0d: got %h, required 0020", i, mem_addr); end
    end
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0021}) begin n_fail++; $display("FAIL stall_lo_issue: got %b %h, required 1 0021", mem_rd, mem_addr); end
    wait_pops(1, "stall");
    n_cmp++; if (pop_log[0] !== {16'h0010, 32'h0A010203}) begin n_fail++; $display("FAIL stall_pop: got %h, required 00100a010203", pop_log[0]); end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_rd: got %b, required 0", mem_rd); end
    n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, 16'h0010}) begin n_fail++; $display("FAIL redir_pre_head: got %b %h, required 1 0010", instr_valid, instr_pc); end
    @(negedge clk);
    redirect    = 1'b0;
    instr_ready = 1'b1;
    clear_logs();
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b, required 0", instr_valid); end
    n_cmp++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0200}) begin n_fail++; $display("FAIL redir_first_rd: got %b %h, required 1 0200", mem_rd, mem_addr); end
    wait_pops(1, "redir");
    n_cmp++; if (rd_log[1] !== 16'h0201) begin n_fail++; $display("FAIL redir_second_rd: got %h, required 0201", rd_log[1]); end
    n_cmp++; if (pop_log[0] !== {16'h0100, 32'h12345678}) begin n_fail++; $display("FAIL redir_pop: got %h, required 010012345678", pop_log[0]); end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    mem_gnt  = 1'b1;
    clear_logs();
    wait_pops(2, "wrap");
    n_cmp++; if ({rd_log[0], rd_log[1]} !== {16'hFFFE, 16'hFFFF}) begin n_fail++; $display("FAIL wrap_rd_hi: got %h %h, required fffe ffff", rd_log[0], rd_log[1]); end
    n_cmp++; if ({rd_log[2], rd_log[3]} !== {16'h0000, 16'h0001}) begin n_fail++; $display("FAIL wrap_rd_lo: got %h %h, required 0000 0001", rd_log[2], rd_log[3]); end
    n_cmp++; if (pop_log[0] !== {16'hFFFF, 32'hCAFEF00D}) begin n_fail++; $display("FAIL wrap_pop0: got %h, required ffffcafef00d", pop_log[0]); end
    n_cmp++; if (pop_log[1] !== {16'h0000, 32'h11112222}) begin n_fail++; $display("FAIL wrap_pop1: got %h, required 000011112222", pop_log[1]); end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b1, 1'b1);
    repeat (7) @(negedge clk);
    #1;
    n_cmp++; if ({instr_valid, mem_rd} !== 2'b11) begin n_fail++; $display("FAIL mrst_pre: got %b%b, required 11", instr_valid, mem_rd); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_rd, mem_addr} !== 17'h0) begin n_fail++; $display("FAIL mrst_mem: got %b %h, required 0 0000", mem_rd, mem_addr); end
    n_cmp++; if ({instr_valid, instr_pc, instr} !== 49'h0) begin n_fail++; $display("FAIL mrst_out: got %b %h %h, required 0 0000 00000000", instr_valid, instr_pc, instr); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    wait_pops(1, "mrst");
    n_cmp++; if (rd_log[0] !== 16'h0020) begin n_fail++; $display("FAIL mrst_restart_rd: got %h, required 0020", rd_log[0]); end
    n_cmp++; if (pop_log[0] !== {16'h0010, 32'h0A010203}) begin n_fail++; $display("FAIL mrst_pop: got %h, required 00100a010203", pop_log[0]); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = ~16'(i);
    mem[16'h0020] = 16'h0A01;
    mem[16'h0021] = 16'h0203;
    mem[16'h0200] = 16'h1234;
    mem[16'h0201] = 16'h5678;
    mem[16'hFFFE] = 16'hCAFE;
    mem[16'hFFFF] = 16'hF00D;
    mem[16'h0000] = 16'h1111;
    mem[16'h0001] = 16'h2222;

    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_wrap();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
